pipe_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage core. Each cycle it decides which pipeline registers advance, hold or take a bubble. It detects load-use hazards between the ID and EX stages. It also stalls the whole pipe while the MEM stage waits on a variable-latency data memory (req/ready handshake), and latches a hard error if that memory never answers.

---
 rtl/pipe_pkg.sv | 16 +
 rtl/hazard_detect.sv | 30 +++
 rtl/pipe_ctrl.sv | 158 +++++++++++++++
 tb/tb_pipe_ctrl.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared encodings for the pipeline sequencer and the control decoder:
// FSM states, opcode constants and register-address width.
package pipe_pkg;
    localparam int REG_ADDR_W = 5;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b000001;
    localparam logic [5:0] OP_LW    = 6'b000010;
    localparam logic [5:0] OP_SW    = 6'b000011;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_ERR      = 2'b10
    } state_e;
endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use hazard check between the load in EX and the
// instruction in ID; also reports whether the ID opcode reads rt.
module hazard_detect
    import pipe_pkg::*;
(
    input  logic                  id_valid_i,
    input  logic [5:0]            id_opcode_i,
    input  logic [REG_ADDR_W-1:0] id_rs_i,
    input  logic [REG_ADDR_W-1:0] id_rt_i,
    input  logic                  ex_valid_i,
    input  logic                  ex_mem_read_i,
    input  logic [REG_ADDR_W-1:0] ex_rt_i,
    output logic                  lu_o,
    output logic                  uses_rt_o
);
    logic uses_rs;
    logic rs_hit;
    logic rt_hit;

    assign uses_rt_o = (id_opcode_i == OP_RTYPE) || (id_opcode_i == OP_SW);
    assign uses_rs   = (id_opcode_i == OP_RTYPE) || (id_opcode_i == OP_ORI) ||
                       (id_opcode_i == OP_LW)    || (id_opcode_i == OP_SW);

    assign rs_hit = uses_rs   && (ex_rt_i == id_rs_i);
    assign rt_hit = uses_rt_o && (ex_rt_i == id_rt_i);

    // r0 is hardwired, so a load targeting it never creates a dependency
    assign lu_o = ex_valid_i && ex_mem_read_i && id_valid_i &&
                  (ex_rt_i != '0) && (rs_hit || rt_hit);
endmodule

// File: rtl/pipe_ctrl.sv
// 5-stage pipeline sequencer: load-use bubbles, data-memory wait freeze,
// sticky timeout error and saturating stall / load-use counters.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [5:0]            id_opcode,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  ex_valid,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    input  logic                  mem_valid,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic                  dmem_ready,
    output logic                  dmem_req,
    output logic                  pc_en,
    output logic                  if_id_en,
    output logic                  id_ex_en,
    output logic                  ex_mem_en,
    output logic                  mem_wb_en,
    output logic                  id_ex_bubble,
    output logic                  mem_wb_bubble,
    output logic [1:0]            state,
    output logic                  err,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      lu_cnt
);
    localparam int WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic [CNT_W-1:0]  lu_q, lu_d;

    logic lu;
    logic id_uses_rt_unused;  // decoder-facing; the sequencer only needs lu
    logic macc;
    logic stall_inc, lu_inc;
    logic req_c, pc_c, ifid_c, idex_c, exmem_c, memwb_c, idexb_c, memwbb_c;

    hazard_detect u_hazard (
        .id_valid_i    (id_valid),
        .id_opcode_i   (id_opcode),
        .id_rs_i       (id_rs),
        .id_rt_i       (id_rt),
        .ex_valid_i    (ex_valid),
        .ex_mem_read_i (ex_mem_read),
        .ex_rt_i       (ex_rt),
        .lu_o          (lu),
        .uses_rt_o     (id_uses_rt_unused)
    );

    assign macc = mem_valid && (mem_read || mem_write);

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        err_d     = err_q;
        stall_inc = 1'b0;
        lu_inc    = 1'b0;
        req_c     = 1'b0;
        pc_c      = 1'b0;
        ifid_c    = 1'b0;
        idex_c    = 1'b0;
        exmem_c   = 1'b0;
        memwb_c   = 1'b0;
        idexb_c   = 1'b0;
        memwbb_c  = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                req_c = macc;
                if (macc && !dmem_ready) begin
                    // freeze everything; MEM/WB drains a NOP so WB does not repeat
                    memwb_c   = 1'b1;
                    memwbb_c  = 1'b1;
                    stall_inc = 1'b1;
                    wait_d    = '0;
                    state_d   = ST_MEM_WAIT;
                end else if (lu) begin
                    idex_c    = 1'b1;
                    idexb_c   = 1'b1;
                    exmem_c   = 1'b1;
                    memwb_c   = 1'b1;
                    stall_inc = 1'b1;
                    lu_inc    = 1'b1;
                end else begin
                    {pc_c, ifid_c, idex_c, exmem_c, memwb_c} = '1;
                end
            end
            ST_MEM_WAIT: begin
                req_c = 1'b1;
                if (dmem_ready) begin
                    {pc_c, ifid_c, idex_c, exmem_c, memwb_c} = '1;
                    state_d = ST_RUN;
                end else begin
                    memwb_c   = 1'b1;
                    memwbb_c  = 1'b1;
                    stall_inc = 1'b1;
                    if (wait_q == WAIT_LAST) begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                    end else begin
                        wait_d = wait_q + 1'b1;
                    end
                end
            end
            ST_ERR: begin
                err_d = 1'b1;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    assign stall_d = (stall_inc && (stall_q != '1)) ? stall_q + 1'b1 : stall_q;
    assign lu_d    = (lu_inc && (lu_q != '1)) ? lu_q + 1'b1 : lu_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            wait_q  <= '0;
            err_q   <= 1'b0;
            stall_q <= '0;
            lu_q    <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
            stall_q <= stall_d;
            lu_q    <= lu_d;
        end
    end

    // reset gates the combinational outputs so an aborted access drops req at once
    assign dmem_req      = rst_n && req_c;
    assign pc_en         = rst_n && pc_c;
    assign if_id_en      = rst_n && ifid_c;
    assign id_ex_en      = rst_n && idex_c;
    assign ex_mem_en     = rst_n && exmem_c;
    assign mem_wb_en     = rst_n && memwb_c;
    assign id_ex_bubble  = rst_n && idexb_c;
    assign mem_wb_bubble = rst_n && memwbb_c;

    assign state     = state_q;
    assign err       = err_q;
    assign stall_cnt = stall_q;
    assign lu_cnt    = lu_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomized bench for pipe_ctrl: a cycle-level reference model pushes the
// expected outputs into a queue; a negedge monitor pops and compares.
module tb_pipe_ctrl;
    import pipe_pkg::*;

    localparam int TO   = 4;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;
    localparam int NCYC = 4000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          id_valid, ex_valid, ex_mem_read, mem_valid, mem_read, mem_write, dmem_ready;
    logic [5:0]    id_opcode;
    logic [4:0]    id_rs, id_rt, ex_rt;
    logic          dmem_req, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic          id_ex_bubble, mem_wb_bubble, err;
    logic [1:0]    state;
    logic [CW-1:0] stall_cnt, lu_cnt;

    always #5 clk = ~clk;

    pipe_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
        .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
        .mem_valid(mem_valid), .mem_read(mem_read), .mem_write(mem_write),
        .dmem_ready(dmem_ready), .dmem_req(dmem_req),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
        .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
        .id_ex_bubble(id_ex_bubble), .mem_wb_bubble(mem_wb_bubble),
        .state(state), .err(err), .stall_cnt(stall_cnt), .lu_cnt(lu_cnt)
    );

    typedef struct {
        logic [6:0] en;   // {pc, if_id, id_ex, ex_mem, mem_wb, id_ex_bubble, mem_wb_bubble}
        logic       req;
        int         st;
        logic       er;
        int         stall;
        int         lu;
    } exp_t;

    exp_t q[$];
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, expv, $time);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("enables", int'({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                                     id_ex_bubble, mem_wb_bubble}), int'(e.en));
                chk("dmem_req", int'(dmem_req), int'(e.req));
                chk("state", int'(state), e.st);
                chk("err", int'(err), int'(e.er));
                chk("stall_cnt", int'(stall_cnt), e.stall);
                chk("lu_cnt", int'(lu_cnt), e.lu);
            end
        end
    end

    function automatic int sat(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    // Which register fields an opcode reads, straight from the ISA table
    function automatic bit hazard();
        bit reads_rs, reads_rt;
        reads_rs = id_opcode inside {6'd0, 6'd1, 6'd2, 6'd3};
        reads_rt = id_opcode inside {6'd0, 6'd3};
        return ex_valid && ex_mem_read && id_valid && (ex_rt != 5'd0) &&
               ((reads_rs && ex_rt == id_rs) || (reads_rt && ex_rt == id_rt));
    endfunction

    // Model: memory access tracked as "k cycles since the first request"
    bit m_busy, m_dead, n_busy, n_dead;
    int m_k, m_stall, m_lu, n_k, n_stall, n_lu;

    initial begin
        exp_t e;
        bit   quiet, macc;
        rst_n = 1'b0;
        {id_valid, ex_valid, ex_mem_read, mem_valid, mem_read, mem_write, dmem_ready} = '0;
        id_opcode = '0; id_rs = '0; id_rt = '0; ex_rt = '0;
        {m_busy, m_dead, n_busy, n_dead} = '0;
        {m_k, m_stall, m_lu, n_k, n_stall, n_lu} = '0;

        for (int i = 0; i < NCYC; i++) begin
            @(posedge clk);
            m_busy = n_busy; m_dead = n_dead; m_k = n_k; m_stall = n_stall; m_lu = n_lu;
            #1;
            quiet       = ((i / 100) % 3) == 2;
            rst_n       = (i < 3) ? 1'b0 : ($urandom_range(0, 59) != 0);
            id_valid    = $urandom_range(0, 3) != 0;
            id_opcode   = 6'($urandom_range(0, 5));
            id_rs       = 5'($urandom_range(0, 3));
            id_rt       = 5'($urandom_range(0, 3));
            ex_valid    = $urandom_range(0, 3) != 0;
            ex_mem_read = $urandom_range(0, 1) != 0;
            ex_rt       = 5'($urandom_range(0, 3));
            mem_valid   = $urandom_range(0, 3) != 0;
            mem_read    = $urandom_range(0, 2) == 0;
            mem_write   = $urandom_range(0, 3) == 0;
            dmem_ready  = quiet ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 1) != 0);

            e.en = '0; e.req = 1'b0;
            if (!rst_n) begin
                {m_busy, m_dead} = '0;
                {m_k, m_stall, m_lu} = '0;
            end
            n_busy = m_busy; n_dead = m_dead; n_k = m_k; n_stall = m_stall; n_lu = m_lu;
            e.st = m_dead ? 2 : (m_busy ? 1 : 0);
            e.er = m_dead;
            e.stall = m_stall;
            e.lu = m_lu;

            if (rst_n && !m_dead) begin
                macc = mem_valid && (mem_read || mem_write);
                if (m_busy) begin
                    e.req = 1'b1;
                    if (dmem_ready) begin
                        e.en = 7'b1111100;
                        n_busy = 1'b0;
                    end else begin
                        e.en = 7'b0000101;
                        n_stall = sat(m_stall);
                        if (m_k == TO) begin
                            n_busy = 1'b0;
                            n_dead = 1'b1;
                        end else begin
                            n_k = m_k + 1;
                        end
                    end
                end else begin
                    e.req = macc;
                    if (macc && !dmem_ready) begin
                        e.en = 7'b0000101;
                        n_stall = sat(m_stall);
                        n_busy = 1'b1;
                        n_k = 1;
                    end else if (hazard()) begin
                        e.en = 7'b0011110;
                        n_stall = sat(m_stall);
                        n_lu = sat(m_lu);
                    end else begin
                        e.en = 7'b1111100;
                    end
                end
            end
            q.push_back(e);
        end

        repeat (2) @(posedge clk);
        chk("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
